// File: rtl/seg_display_arbiter.sv
// Shares one 4-digit 7-segment display between three requesters: a fixed-priority
// arbiter with a minimum-hold window picks the owner, a scan controller multiplexes its frame.
module seg_display_arbiter #(
  parameter int SCAN_DIV = 8,
  parameter int HOLD_CYC = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req,
  input  logic [15:0] frame0,
  input  logic [15:0] frame1,
  input  logic [15:0] frame2,
  output logic [2:0]  gnt,
  output logic        owner_valid,
  output logic [3:0]  DIGIT,
  output logic [6:0]  DISPLAY
);

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_OWN  = 1'b1;

  localparam int HW = $clog2(HOLD_CYC + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYC);
  localparam logic [HW-1:0] HOLD_THR = HW'(HOLD_CYC - 1);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  logic          state;
  logic [HW-1:0] hold_cnt;
  logic [2:0]    gnt_n;
  logic [2:0]    lowest;
  logic [2:0]    lower;

  // The state flop doubles as owner_valid so the FSM state is visible on a port.
  assign owner_valid = (state == ST_OWN);

  always_comb begin
    lowest = req & (~req + 3'd1);
    lower  = req & (gnt - 3'd1);
    gnt_n  = gnt;
    case (state)
      ST_IDLE: gnt_n = lowest;
      ST_OWN: begin
        // Release wins over preemption; both resolve to the highest-priority pending client.
        if ((req & gnt) == 3'd0)
          gnt_n = lowest;
        else if (lower != 3'd0 && hold_cnt >= HOLD_THR)
          gnt_n = lowest;
      end
      default: gnt_n = 3'd0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt      <= 3'd0;
      state    <= ST_IDLE;
      hold_cnt <= '0;
    end else begin
      gnt   <= gnt_n;
      state <= (gnt_n != 3'd0) ? ST_OWN : ST_IDLE;
      if (gnt_n != gnt)
        hold_cnt <= '0;
      else if (state == ST_OWN && hold_cnt < HOLD_MAX)
        hold_cnt <= hold_cnt + 1'b1;
    end
  end

  logic [DW-1:0] div;
  logic [1:0]    idx;
  logic [1:0]    idx_n;
  logic [3:0]    value;
  logic [3:0]    value_n;
  logic [15:0]   frame_sel;
  logic          tick;

  assign tick  = (div == DIV_LAST);
  assign idx_n = idx + 2'd1;

  always_comb begin
    case (gnt)
      3'b001:  frame_sel = frame0;
      3'b010:  frame_sel = frame1;
      3'b100:  frame_sel = frame2;
      default: frame_sel = 16'd0;
    endcase
    value_n = (gnt != 3'd0) ? frame_sel[idx_n*4 +: 4] : 4'd12;
  end

  // Digit enable and value load together so the segments always match the lit digit.
  always_ff @(posedge clk) begin
    if (rst) begin
      div   <= '0;
      idx   <= 2'd0;
      DIGIT <= 4'b1110;
      value <= 4'd12;
    end else if (tick) begin
      div   <= '0;
      idx   <= idx_n;
      DIGIT <= ~(4'b0001 << idx_n);
      value <= value_n;
    end else begin
      div <= div + 1'b1;
    end
  end

  always_comb begin
    DISPLAY = 7'b1111111;
    case (value)
      4'd0:  DISPLAY = 7'b1000000;
      4'd1:  DISPLAY = 7'b1111001;
      4'd2:  DISPLAY = 7'b0100100;
      4'd3:  DISPLAY = 7'b0110000;
      4'd4:  DISPLAY = 7'b0011001;
      4'd5:  DISPLAY = 7'b0010010;
      4'd6:  DISPLAY = 7'b0000010;
      4'd7:  DISPLAY = 7'b1111000;
      4'd8:  DISPLAY = 7'b0000000;
      4'd9:  DISPLAY = 7'b0010000;
      4'd10: DISPLAY = 7'b0001000;
      4'd11: DISPLAY = 7'b0000011;
      4'd12: DISPLAY = 7'b0111111;
      default: DISPLAY = 7'b1111111;
    endcase
  end

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Randomized bench for seg_display_arbiter: a cycle-level reference model of owner,
// hold age and scan position predicts gnt, owner_valid, DIGIT and DISPLAY every cycle.
module tb_seg_display_arbiter;

  localparam int SCAN_DIV = 8;
  localparam int HOLD_CYC = 64;

  logic        clk;
  logic        rst;
  logic [2:0]  req;
  logic [15:0] frame0;
  logic [15:0] frame1;
  logic [15:0] frame2;
  logic [2:0]  gnt;
  logic        owner_valid;
  logic [3:0]  DIGIT;
  logic [6:0]  DISPLAY;

  seg_display_arbiter #(.SCAN_DIV(SCAN_DIV), .HOLD_CYC(HOLD_CYC)) dut (
    .clk(clk), .rst(rst), .req(req),
    .frame0(frame0), .frame1(frame1), .frame2(frame2),
    .gnt(gnt), .owner_valid(owner_valid), .DIGIT(DIGIT), .DISPLAY(DISPLAY)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h expected %h", tag, $time, got, exp);
    end
  endtask

  logic [6:0] seg_tab [16];
  initial begin
    seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001; seg_tab[2]  = 7'b0100100;
    seg_tab[3]  = 7'b0110000; seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
    seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000; seg_tab[8]  = 7'b0000000;
    seg_tab[9]  = 7'b0010000; seg_tab[10] = 7'b0001000; seg_tab[11] = 7'b0000011;
    seg_tab[12] = 7'b0111111; seg_tab[13] = 7'b1111111; seg_tab[14] = 7'b1111111;
    seg_tab[15] = 7'b1111111;
  end

  // Reference model: owner index (-1 = none), edges since grant, cycles in slot, shown digit.
  int m_owner = -1;
  int m_age   = 0;
  int m_cnt   = 0;
  int m_idx   = 0;
  int m_val   = 12;
  bit m_live  = 0;

  function automatic int lowest_req(input logic [2:0] r);
    for (int i = 0; i < 3; i++)
      if (r[i]) return i;
    return -1;
  endfunction

  function automatic int nibble_of(input int o, input int d);
    logic [15:0] f;
    f = (o == 0) ? frame0 : (o == 1) ? frame1 : frame2;
    return int'(f[d*4 +: 4]);
  endfunction

  always @(posedge clk) begin
    int nxt;
    if (rst) begin
      m_owner = -1; m_age = 0; m_cnt = 0; m_idx = 0; m_val = 12; m_live = 1;
    end else if (m_live) begin
      nxt = m_owner;
      if (m_owner < 0)
        nxt = lowest_req(req);
      else if (!req[m_owner])
        nxt = lowest_req(req);
      else if (lowest_req(req) < m_owner && m_age >= HOLD_CYC - 1)
        nxt = lowest_req(req);
      // Scan samples the owner that was in place before this edge.
      m_cnt++;
      if (m_cnt == SCAN_DIV) begin
        m_cnt = 0;
        m_idx = (m_idx + 1) % 4;
        m_val = (m_owner >= 0) ? nibble_of(m_owner, m_idx) : 12;
      end
      m_age = (nxt != m_owner) ? 0 : m_age + 1;
      m_owner = nxt;
    end
    if (m_live) begin
      #2;
      check("gnt", 16'(gnt), (m_owner >= 0) ? 16'(3'b001 << m_owner) : 16'd0);
      check("owner_valid", 16'(owner_valid), 16'(m_owner >= 0));
      check("DIGIT", 16'(DIGIT), 16'(~(4'b0001 << m_idx) & 4'hF));
      check("DISPLAY", 16'(DISPLAY), 16'(seg_tab[m_val]));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rst;
    rst = 1'b1;
    cycles(1);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1; req = 3'b000;
    frame0 = 16'h0000; frame1 = 16'h5678; frame2 = 16'h0000;
    cycles(2);
    rst = 1'b0;
    cycles(40);                                   // idle: dashes, digit rotation

    frame2 = 16'h1234; req = 3'b100; cycles(11);  // client 2 owns
    req = 3'b101; frame0 = 16'h0000; cycles(100); // preempted after hold window
    req = 3'b011; cycles(200);                    // lower priority never preempts
    req = 3'b010; cycles(40);                     // release hands over directly
    req = 3'b000; cycles(5);
    frame0 = 16'hABCF; req = 3'b111; cycles(40);  // A, b, dash, blank
    req = 3'b010; cycles(20);
    pulse_rst(); cycles(20);                      // reset mid-scan with req held

    for (int it = 0; it < 300; it++) begin
      req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 3) == 0) frame0 = 16'($urandom);
      if ($urandom_range(0, 3) == 0) frame1 = 16'($urandom);
      if ($urandom_range(0, 3) == 0) frame2 = 16'($urandom);
      if ($urandom_range(0, 49) == 0) pulse_rst();
      cycles($urandom_range(1, 90));
    end

    cycles(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_display_arbiter.md
Name: seg_display_arbiter

Overview:
- Shares the single 4-digit 7-segment display between three requesters, e.g. game core, round timer and score/status unit.
- A fixed-priority arbiter with a minimum-hold window selects which requester owns the display.
- A scan controller time-multiplexes the owner's 16-bit nibble frame across the four digits.
- Sits between the game-level FSMs and the board DIGIT/DISPLAY pins; replaces the per-module ad-hoc scan logic.

Parameters:
- SCAN_DIV, default 8: clk cycles per digit slot. Board build uses 16384.
- HOLD_CYC, default 64: minimum cycles an owner keeps the display before a higher-priority requester may preempt it.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, synchronous, active-high
- req  input  3  request per client; bit 0 is highest priority
- frame0  input  16  client 0 frame; nibble k drives digit k (digit 0 = rightmost)
- frame1  input  16  client 1 frame
- frame2  input  16  client 2 frame
- gnt  output  3  registered one-hot grant, or 000 when no owner
- owner_valid  output  1  registered; high when gnt != 000
- DIGIT  output  4  registered active-low digit enable
- DISPLAY  output  7  active-low segments {g,f,e,d,c,b,a}

Behaviour:
- Reset values:
  - gnt=000, owner_valid=0, hold_cnt=0.
  - Scan divider=0, digit index=0, DIGIT=4'b1110.
  - Value register=12, so DISPLAY=7'b0111111 (dash).
- Arbiter FSM, state IDLE:
  - On any req set, grant the lowest-index set bit at the next edge (1-cycle latency).
  - Otherwise remain in IDLE.
- Arbiter FSM, state OWN(k):
  - If req[k]=0: release at the next edge.
  - On that same edge, if other reqs are pending, grant the highest-priority pending client directly, with no IDLE gap. If none are pending, go to IDLE.
  - If req[k]=1, a lower-index req j is set, and hold_cnt>=HOLD_CYC-1: switch gnt to the lowest such j at the next edge. Grant therefore changes exactly HOLD_CYC cycles after gnt[k] first appeared.
  - Higher-index requests never preempt.
- hold_cnt:
  - Cleared on every edge that changes gnt.
  - Otherwise increments while owner_valid, saturating at HOLD_CYC.
- Simultaneous events: an owner dropping its request while others request resolves to the highest-priority pending client. Release takes precedence over the preempt check.
- Scan divider:
  - Counts 0..SCAN_DIV-1 and wraps.
  - Scan tick occurs when the divider reaches SCAN_DIV-1.
  - On a tick, the digit index advances 0→1→2→3→0.
  - DIGIT is updated on the same edge: 1110, 1101, 1011, 0111.
  - The value register loads the nibble of the new digit on the same edge, so DIGIT and value always correspond.
- Value source:
  - Owner's frame nibble[4*idx+3:4*idx].
  - If no owner: 4'd12.
  - Frame is sampled only at scan ticks, so a change becomes visible within 4*SCAN_DIV cycles.
- DISPLAY decode, combinational from the value register:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - 10(A)=0001000, 11(b)=0000011, 12(-)=0111111.
  - 13-15: blank, 1111111.
- Scan runs continuously, independent of arbitration. Grant changes do not reset the scan position.
- Reset mid-operation: all state returns to reset values at the next edge, regardless of owner or scan position.

Test Plan:
1. Reset, req=000, 40 cycles -> gnt=000 and owner_valid=0. DIGIT steps 1110→1101→1011→0111→1110 every 8 cycles. DISPLAY=0111111 in every slot.
2. req=100, frame2=16'h1234 -> gnt=100 one cycle after req. In slot 1110 DISPLAY=0011001 ('4'); in slot 0111 DISPLAY=1111001 ('1').
3. Client 2 owns; req[0] rises 10 cycles after grant, frame0=16'h0000 -> gnt stays 100 until exactly 64 cycles after grant, then becomes 001. All digits show 1000000 within 32 cycles.
4. Client 0 owns; req[1] held high -> no preemption over 200 cycles. req[0] drops -> gnt=010 on the next edge, with owner_valid never low.
5. From IDLE, req=111, frame0=16'hABCF -> gnt=001. Slot 1110 shows 1111111, 1101 shows 0111111, 1011 shows 0000011, 0111 shows 0001000.
6. Owner 1 active, scan at digit 2, rst pulsed one cycle -> next edge gnt=000, DIGIT=1110, DISPLAY=0111111, hold_cnt=0. With req[1] still high, gnt=010 one cycle after rst deasserts.
